// File: rtl/boot_loader_pkg.sv
// Shared constants for the boot loader: FSM state encoding, BRAM geometry and checksum width.
// The default address width matches the bram16 instance the loader writes through port B.
package boot_loader_pkg;

    localparam int BL_ADDR_WIDTH = 9;
    localparam int BL_CHK_WIDTH  = 8;
    localparam int BL_STATE_W    = 3;

    localparam logic [BL_STATE_W-1:0] BL_LEN_HI  = 3'd0;
    localparam logic [BL_STATE_W-1:0] BL_LEN_LO  = 3'd1;
    localparam logic [BL_STATE_W-1:0] BL_DATA_HI = 3'd2;
    localparam logic [BL_STATE_W-1:0] BL_DATA_LO = 3'd3;
    localparam logic [BL_STATE_W-1:0] BL_WRITE   = 3'd4;
    localparam logic [BL_STATE_W-1:0] BL_CHK     = 3'd5;
    localparam logic [BL_STATE_W-1:0] BL_DONE    = 3'd6;
    localparam logic [BL_STATE_W-1:0] BL_ERR     = 3'd7;

endpackage

// File: rtl/boot_word_asm.sv
// Hi/lo byte assembly registers plus running XOR checksum over accepted bytes.
// Updates on the accepting edge; no backpressure of its own, the parent gates byte_vld.
module boot_word_asm
    import boot_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    byte_vld,
    input  logic                    load_hi,
    input  logic                    load_lo,
    input  logic                    chk_en,
    input  logic [7:0]              byte_dat,
    output logic [7:0]              hi_dat,
    output logic [15:0]             word_dat,
    output logic [BL_CHK_WIDTH-1:0] chk_dat
);

    logic [7:0]              hi_q;
    logic [7:0]              lo_q;
    logic [BL_CHK_WIDTH-1:0] chk_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            hi_q  <= '0;
            lo_q  <= '0;
            chk_q <= '0;
        end else if (byte_vld) begin
            if (load_hi) hi_q  <= byte_dat;
            if (load_lo) lo_q  <= byte_dat;
            if (chk_en)  chk_q <= chk_q ^ byte_dat;
        end
    end

    assign hi_dat   = hi_q;
    assign word_dat = {hi_q, lo_q};
    assign chk_dat  = chk_q;

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed, XOR-checksummed word image into BRAM port B, then releases the CPU.
// Lo byte -> BRAM write 1 cycle; checksum byte -> cpu_run 1 cycle; rx_ready drops in WRITE/DONE/ERR and on reload.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = BL_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reload,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_din,
    output logic                  cpu_run,
    output logic                  done,
    output logic                  err
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

    logic [BL_STATE_W-1:0]   state;
    logic [BL_STATE_W-1:0]   state_nxt;
    logic [LEN_W-1:0]        len;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    accept;
    logic [7:0]              asm_hi;
    logic [15:0]             asm_word;
    logic [BL_CHK_WIDTH-1:0] asm_chk;
    logic [15:0]             n_full;
    logic [15:0]             len_hi_ext;
    logic                    len_oversize;
    logic                    len_zero;
    logic                    last_word;
    logic                    in_len_data;

    assign accept = rx_valid && rx_ready;

    // The length hi byte is parked in the word assembler's hi register so the
    // oversize test sees the full 16-bit count, not the truncated len.
    assign n_full       = {asm_hi, rx_data};
    assign len_hi_ext   = {rx_data, 8'h00};
    assign len_oversize = {1'b0, n_full} > DEPTH;
    assign len_zero     = (n_full == 16'h0000);
    assign last_word    = ({1'b0, addr} == (len - LEN_W'(1)));
    assign in_len_data  = (state == BL_LEN_HI) || (state == BL_LEN_LO) ||
                          (state == BL_DATA_HI) || (state == BL_DATA_LO);

    boot_word_asm u_word_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (reload),
        .byte_vld (accept),
        .load_hi  ((state == BL_LEN_HI) || (state == BL_DATA_HI)),
        .load_lo  (state == BL_DATA_LO),
        .chk_en   (in_len_data),
        .byte_dat (rx_data),
        .hi_dat   (asm_hi),
        .word_dat (asm_word),
        .chk_dat  (asm_chk)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BL_LEN_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (reload) begin
            state_nxt = BL_LEN_HI;
        end else begin
            case (state)
                BL_LEN_HI: if (accept) state_nxt = BL_LEN_LO;
                BL_LEN_LO: begin
                    if (accept) begin
                        if (len_oversize)  state_nxt = BL_ERR;
                        else if (len_zero) state_nxt = BL_CHK;
                        else               state_nxt = BL_DATA_HI;
                    end
                end
                BL_DATA_HI: if (accept) state_nxt = BL_DATA_LO;
                BL_DATA_LO: if (accept) state_nxt = BL_WRITE;
                BL_WRITE:   state_nxt = last_word ? BL_CHK : BL_DATA_HI;
                BL_CHK: begin
                    if (accept) state_nxt = (rx_data == asm_chk) ? BL_DONE : BL_ERR;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || reload) begin
            len  <= '0;
            addr <= '0;
        end else begin
            if (accept && (state == BL_LEN_HI)) len <= len_hi_ext[LEN_W-1:0];
            if (accept && (state == BL_LEN_LO)) len <= n_full[LEN_W-1:0];
            // addr stops at the last word; the next load starts from reset/reload.
            if ((state == BL_WRITE) && !last_word) addr <= addr + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        rx_ready = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = addr;
        mem_din  = 16'h0000;
        cpu_run  = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            BL_LEN_HI, BL_LEN_LO, BL_DATA_HI, BL_DATA_LO, BL_CHK: rx_ready = !reload;
            BL_WRITE: begin
                mem_en  = 1'b1;
                mem_we  = 1'b1;
                mem_din = asm_word;
            end
            BL_DONE: begin
                cpu_run = 1'b1;
                done    = 1'b1;
            end
            BL_ERR: err = 1'b1;
            default: rx_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: table-driven image vectors plus hand sequences, BRAM writes checked
// against an expected-write queue filled as bytes are driven.
module tb_boot_loader;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reload = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic          cpu_run;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reload   (reload),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .cpu_run  (cpu_run),
        .done     (done),
        .err      (err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   dat;
    } wr_t;

    typedef struct packed {
        logic [63:0] img;
        logic [3:0]  nb;
        logic [2:0]  maxgap;
        logic        exp_done;
        logic        exp_err;
        logic [3:0]  exp_wr;
    } vec_t;

    typedef logic [7:0] byte_q_t[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          write_cnt = 0;
    logic [15:0] bram [0:(1<<AW)-1];
    wr_t         exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // BRAM model and write scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_en && mem_we) begin
            wr_t e;
            write_cnt++;
            bram[mem_addr] = mem_din;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h, want no write", mem_addr, mem_din);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(e.addr));
                check("write_data", 32'(mem_din), 32'(e.dat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        write_cnt = 0;
        exp_q.delete();
    endtask

    task automatic push_exp(input int a, input logic [15:0] d);
        wr_t e;
        e.addr = AW'(a);
        e.dat  = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (rx_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        rx_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got rx_ready low for 20 cycles, want byte %0h accepted", b);
        end
    endtask

    // Drives an image; for every lo data byte queues the write the image format implies.
    task automatic send_image(input byte_q_t img, input int maxgap);
        int  n;
        bit  ok;
        bit  is_lo;
        n = 0;
        for (int i = 0; i < img.size(); i++) begin
            if (i == 1) n = int'({img[0], img[1]});
            is_lo = (i >= 2) && (n <= (1 << AW)) && (i < 2 + 2 * n) && (((i - 2) % 2) == 1);
            if (is_lo) push_exp((i - 2) / 2, {img[i-1], img[i]});
            send_byte(img[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0, ok);
            if (!ok) return;
            if (is_lo) check("write_latency", {31'b0, mem_we && mem_en}, 32'd1);
        end
    endtask

    vec_t    tbl [8];
    byte_q_t q;
    bit      ok;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{img: 64'h0002_1234_ABCD_4200, nb: 4'd7, maxgap: 3'd0, exp_done: 1'b1, exp_err: 1'b0, exp_wr: 4'd2};
        tbl[1] = '{img: 64'h0002_1234_ABCD_4300, nb: 4'd7, maxgap: 3'd0, exp_done: 1'b0, exp_err: 1'b1, exp_wr: 4'd2};
        tbl[2] = '{img: 64'h0000_0000_0000_0000, nb: 4'd3, maxgap: 3'd0, exp_done: 1'b1, exp_err: 1'b0, exp_wr: 4'd0};
        tbl[3] = '{img: 64'h0201_0000_0000_0000, nb: 4'd2, maxgap: 3'd0, exp_done: 1'b0, exp_err: 1'b1, exp_wr: 4'd0};
        tbl[4] = '{img: 64'h0002_1234_ABCD_4200, nb: 4'd7, maxgap: 3'd5, exp_done: 1'b1, exp_err: 1'b0, exp_wr: 4'd2};
        tbl[5] = '{img: 64'h0000_0100_0000_0000, nb: 4'd3, maxgap: 3'd2, exp_done: 1'b0, exp_err: 1'b1, exp_wr: 4'd0};
        tbl[6] = '{img: 64'h0001_FFFF_0100_0000, nb: 4'd5, maxgap: 3'd1, exp_done: 1'b1, exp_err: 1'b0, exp_wr: 4'd1};
        tbl[7] = '{img: 64'h1000_0000_0000_0000, nb: 4'd2, maxgap: 3'd0, exp_done: 1'b0, exp_err: 1'b1, exp_wr: 4'd0};

        // Reset state
        tick();
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_mem_en",   32'(mem_en),   32'd0);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din",  32'(mem_din),  32'd0);
        check("rst_cpu_run",  32'(cpu_run),  32'd0);
        check("rst_done_err", {30'b0, done, err}, 32'd0);

        foreach (tbl[v]) begin
            do_reset();
            q.delete();
            for (int k = 0; k < int'(tbl[v].nb); k++) q.push_back(tbl[v].img[63 - 8*k -: 8]);
            send_image(q, int'(tbl[v].maxgap));
            check($sformatf("v%0d_done", v),     32'(done),     32'(tbl[v].exp_done));
            check($sformatf("v%0d_cpu_run", v),  32'(cpu_run),  32'(tbl[v].exp_done));
            check($sformatf("v%0d_err", v),      32'(err),      32'(tbl[v].exp_err));
            check($sformatf("v%0d_rx_ready", v), 32'(rx_ready), 32'd0);
            tick();
            check($sformatf("v%0d_writes", v),   32'(write_cnt), 32'(tbl[v].exp_wr));
            check($sformatf("v%0d_pending", v),  32'(exp_q.size()), 32'd0);
        end

        // Byte held valid during WRITE must wait for WRITE to end.
        do_reset();
        q = '{8'h00, 8'h02, 8'h12, 8'h34};
        send_image(q, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        #1;
        check("stall_rx_ready", 32'(rx_ready), 32'd0);
        push_exp(1, 16'hABCD);
        send_byte(8'hAB, 0, ok);
        send_byte(8'hCD, 0, ok);
        check("stall_write1", 32'(mem_we), 32'd1);
        send_byte(8'h42, 0, ok);
        check("stall_done", {30'b0, done, err}, 32'd2);
        check("stall_bram", {bram[0], bram[1]}, 32'h1234_ABCD);

        // Reload mid-load with a byte offered in the same cycle.
        do_reset();
        q = '{8'h00, 8'h02, 8'h12, 8'h34};
        send_image(q, 0);
        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        #1;
        check("reload_rx_ready", 32'(rx_ready), 32'd0);
        tick();
        reload   = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("reload_state", {29'b0, rx_ready, mem_en, done}, 32'd4);
        write_cnt = 0;
        bram[0] = 16'h0000;
        bram[1] = 16'h0000;
        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_image(q, 0);
        check("reload_done", {29'b0, cpu_run, done, err}, 32'd6);
        check("reload_bram", {bram[0], bram[1]}, 32'h1234_ABCD);
        check("reload_writes", 32'(write_cnt), 32'd2);

        // Full-depth image: N = 2^AW, last write lands at the top address.
        begin
            logic [7:0]  c;
            logic [15:0] w;
            do_reset();
            q = '{8'h02, 8'h00};
            c = 8'h02;
            for (int k = 0; k < (1 << AW); k++) begin
                w = 16'(k * 7 + 16'h1357);
                q.push_back(w[15:8]);
                q.push_back(w[7:0]);
                c = c ^ w[15:8] ^ w[7:0];
            end
            q.push_back(c);
            send_image(q, 0);
            check("full_done", {29'b0, cpu_run, done, err}, 32'd6);
            check("full_writes", 32'(write_cnt), 32'(1 << AW));
            check("full_last", 32'(bram[(1<<AW)-1]), 32'(16'(((1 << AW) - 1) * 7 + 16'h1357)));
        end

        // Reset from DONE, then a fresh load.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_done_outs", {28'b0, cpu_run, done, err, rx_ready}, 32'd1);
        write_cnt = 0;
        exp_q.delete();
        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_image(q, 2);
        check("rst_reload_done", {29'b0, cpu_run, done, err}, 32'd6);
        check("rst_reload_bram", {bram[0], bram[1]}, 32'h1234_ABCD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
